// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bundle for the sequential ALU.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   typedef struct packed {
      logic zero;
      logic ovr;
      logic neg;
      logic carry;
   } flags_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath for SHL (one bit per step) and shift-add MUL (one partial product per step).
// The *_c outputs show the result and flags the current step will produce, so the caller can load them on the last step.
module alu_iter_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             mul,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] res_c,
   output logic             ovr_c,
   output logic             carry_c,
   output logic             last_c
);

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_nxt;
   logic [WIDTH-1:0]   mcand;
   logic [CNT_W-1:0]   cnt;
   logic               is_mul;
   logic               sovr;
   logic [WIDTH:0]     sum;

   // MUL keeps {high partial, remaining multiplier}; SHL uses the low half only
   always_comb begin
      sum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
      prod_nxt = '0;
      if (is_mul)
         prod_nxt = {sum, prod[WIDTH-1:1]};
      else
         prod_nxt = {{WIDTH{1'b0}}, prod[WIDTH-2:0], 1'b0};
   end

   assign res_c   = prod_nxt[WIDTH-1:0];
   assign ovr_c   = is_mul ? (|prod_nxt[2*WIDTH-1:WIDTH]) : (sovr | prod[WIDTH-1]);
   assign carry_c = is_mul ? 1'b0 : prod[WIDTH-1];
   assign last_c  = (cnt == CNT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod   <= '0;
         mcand  <= '0;
         cnt    <= '0;
         is_mul <= 1'b0;
         sovr   <= 1'b0;
      end else if (load) begin
         prod   <= {{WIDTH{1'b0}}, (mul ? b : a)};
         mcand  <= a;
         cnt    <= count;
         is_mul <= mul;
         sovr   <= 1'b0;
      end else if (step) begin
         prod <= prod_nxt;
         cnt  <= cnt - CNT_W'(1);
         sovr <= sovr | prod[WIDTH-1];
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with start/busy/done handshake; single-cycle logic/arith ops,
// iterative SHL and MUL delegated to alu_iter_unit.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       CNTL,
   output logic [WIDTH-1:0] Y,
   output logic             zero,
   output logic             ovr,
   output logic             neg,
   output logic             carry,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_t           state;
   flags_t           flg;
   logic [WIDTH-1:0] res_c;
   logic [WIDTH:0]   ext_c;
   logic             cy_c;
   logic             ov_c;
   logic [CNT_W-1:0] shamt_c;
   logic [CNT_W-1:0] count_c;
   logic             iter_c;
   logic             load_c;
   logic [WIDTH-1:0] it_res_c;
   logic             it_ovr_c;
   logic             it_carry_c;
   logic             it_last_c;

   function automatic flags_t make_flags(input logic [WIDTH-1:0] y, input logic v, input logic c);
      flags_t f;
      f.zero  = (y == '0);
      f.ovr   = v;
      f.neg   = y[WIDTH-1];
      f.carry = c;
      return f;
   endfunction

   // Single-cycle result; SHL by zero falls through to pass-through of A
   always_comb begin
      res_c = A;
      ext_c = '0;
      cy_c  = 1'b0;
      ov_c  = 1'b0;
      case (CNTL)
         OP_ADD: begin
            ext_c = {1'b0, A} + {1'b0, B};
            res_c = ext_c[WIDTH-1:0];
            cy_c  = ext_c[WIDTH];
            ov_c  = (A[WIDTH-1] == B[WIDTH-1]) && (res_c[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            ext_c = {1'b0, A} - {1'b0, B};
            res_c = ext_c[WIDTH-1:0];
            cy_c  = ext_c[WIDTH];
            ov_c  = (A[WIDTH-1] != B[WIDTH-1]) && (res_c[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND:  res_c = A & B;
         OP_OR:   res_c = A | B;
         OP_XOR:  res_c = A ^ B;
         OP_NOT:  res_c = ~A;
         default: res_c = A;
      endcase
   end

   assign shamt_c = (B >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(B);
   assign count_c = (CNTL == OP_MUL) ? CNT_W'(WIDTH) : shamt_c;
   assign iter_c  = (CNTL == OP_MUL) || ((CNTL == OP_SHL) && (shamt_c != '0));
   assign load_c  = start && (state != ITER) && iter_c;

   alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
      .clk     (clk),
      .rst     (rst),
      .load    (load_c),
      .step    (state == ITER),
      .mul     (CNTL == OP_MUL),
      .a       (A),
      .b       (B),
      .count   (count_c),
      .res_c   (it_res_c),
      .ovr_c   (it_ovr_c),
      .carry_c (it_carry_c),
      .last_c  (it_last_c)
   );

   assign zero  = flg.zero;
   assign ovr   = flg.ovr;
   assign neg   = flg.neg;
   assign carry = flg.carry;

   // Control FSM; result and flags only change on a completing edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         Y     <= '0;
         flg   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               if (start) begin
                  if (iter_c) begin
                     state <= ITER;
                     busy  <= 1'b1;
                  end else begin
                     Y     <= res_c;
                     flg   <= make_flags(res_c, ov_c, cy_c);
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            ITER: begin
               if (it_last_c) begin
                  Y     <= it_res_c;
                  flg   <= make_flags(it_res_c, it_ovr_c, it_carry_c);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): expectations queued at start, checked when done pulses.
module tb_alu_seq;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
   localparam logic [2:0] XOR_ = 3'b100, NOT_ = 3'b101, SHL = 3'b110, MUL = 3'b111;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] A, B, Y;
   logic [2:0] CNTL;
   logic       zero, ovr, neg, carry, busy, done;

   typedef struct {
      string      name;
      logic [7:0] y;
      logic       z, v, n, c;
      int         lat;
      int         start_cyc;
   } exp_t;

   exp_t sb[$];
   exp_t last_e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   busy_cnt = 0;

   alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .CNTL(CNTL),
      .Y(Y), .zero(zero), .ovr(ovr), .neg(neg), .carry(carry), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input string name, input logic [2:0] op,
                                  input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      int ia, ib, r, s, sr;
      ia = int'(a);
      ib = int'(b);
      e.name = name;
      e.v = 1'b0;
      e.c = 1'b0;
      e.lat = 1;
      e.start_cyc = 0;
      case (op)
         ADD: begin
            r = ia + ib;  e.y = 8'(r);  e.c = (r > 255);
            sr = int'($signed(a)) + int'($signed(b));
            e.v = (sr > 127) || (sr < -128);
         end
         SUB: begin
            r = ia - ib;  e.y = 8'(r);  e.c = (ia < ib);
            sr = int'($signed(a)) - int'($signed(b));
            e.v = (sr > 127) || (sr < -128);
         end
         AND_: e.y = a & b;
         OR_:  e.y = a | b;
         XOR_: e.y = a ^ b;
         NOT_: e.y = ~a;
         SHL: begin
            s = (ib > 8) ? 8 : ib;
            r = ia << s;
            e.y = 8'(r);
            e.v = ((r >> 8) != 0);
            e.c = (s == 0) ? 1'b0 : (((ia >> (8 - s)) & 1) != 0);
            e.lat = s + 1;
         end
         default: begin
            r = ia * ib;  e.y = 8'(r);  e.v = (r > 255);  e.lat = 9;
         end
      endcase
      e.z = (e.y == 8'h00);
      e.n = e.y[7];
      return e;
   endfunction

   // Drive one start edge and queue its expectation; returns 1 time unit after that edge
   task automatic drive(input string name, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      e = model(name, op, a, b);
      e.start_cyc = cyc + 1;
      sb.push_back(e);
      last_e = e;
      CNTL = op; A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      CNTL = 3'($urandom); A = 8'($urandom); B = 8'($urandom);
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(posedge clk); #2;
         n++;
      end
      if (sb.size() != 0) begin
         check("done_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   task automatic run(input string name, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      drive(name, op, a, b);
      wait_done();
   endtask

   // Output monitor: compares each done pulse against the head of the scoreboard
   initial forever begin
      exp_t e;
      @(posedge clk); #1;
      if (rst) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (sb.size() == 0) begin
               check("spurious_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check({e.name, ".y"}, 32'(Y), 32'(e.y));
               check({e.name, ".flags"}, 32'({zero, ovr, neg, carry}), 32'({e.z, e.v, e.n, e.c}));
               check({e.name, ".latency"}, 32'(cyc - e.start_cyc + 1), 32'(e.lat));
               check({e.name, ".busy_cycles"}, 32'(busy_cnt), 32'(e.lat - 1));
            end
            busy_cnt = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; A = '0; B = '0; CNTL = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.y", 32'(Y), 32'd0);
      check("reset.flags", 32'({zero, ovr, neg, carry}), 32'd0);
      check("reset.busy_done", 32'({busy, done}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #2;

      run("add_7f_01", ADD, 8'h7F, 8'h01);
      run("add_ff_01", ADD, 8'hFF, 8'h01);
      run("sub_00_01", SUB, 8'h00, 8'h01);
      run("sub_80_01", SUB, 8'h80, 8'h01);
      run("mul_0f_03", MUL, 8'h0F, 8'h03);
      run("mul_10_10", MUL, 8'h10, 8'h10);
      run("shl_81_3", SHL, 8'h81, 8'h03);
      run("shl_81_0", SHL, 8'h81, 8'h00);
      run("shl_81_9", SHL, 8'h81, 8'h09);
      run("and", AND_, 8'hF0, 8'h3C);
      run("or", OR_, 8'hA0, 8'h05);
      run("xor", XOR_, 8'hFF, 8'hFF);
      run("not", NOT_, 8'h5A, 8'h00);

      // Result and flags hold while idle
      run("add_hold", ADD, 8'h40, 8'h41);
      repeat (5) @(posedge clk);
      #2;
      check("hold.y", 32'(Y), 32'(last_e.y));
      check("hold.flags", 32'({zero, ovr, neg, carry}), 32'({last_e.z, last_e.v, last_e.n, last_e.c}));

      // start during busy must be ignored
      drive("mul_busy", MUL, 8'h0F, 8'h03);
      check("mul_busy.busy", 32'(busy), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      CNTL = ADD; A = 8'h01; B = 8'h01; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();

      // Back-to-back: start accepted in the done cycle of a single-cycle op
      drive("b2b_add", ADD, 8'h12, 8'h34);
      check("b2b_add.done_cycle", 32'(done), 32'd1);
      drive("b2b_mul", MUL, 8'h07, 8'h06);
      wait_done();

      // Back-to-back after an iterative op
      drive("b2b_shl", SHL, 8'h81, 8'h03);
      n = 0;
      while (!done && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("b2b_shl.done_seen", 32'(done), 32'd1);
      drive("b2b_sub", SUB, 8'h05, 8'h07);
      wait_done();

      // Asynchronous reset during MUL aborts with no done
      run("pre_abort", ADD, 8'h12, 8'h34);
      CNTL = MUL; A = 8'hFF; B = 8'hFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("abort.y", 32'(Y), 32'd0);
      check("abort.flags", 32'({zero, ovr, neg, carry}), 32'd0);
      check("abort.busy_done", 32'({busy, done}), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #2;
      run("post_abort", ADD, 8'h01, 8'h01);
      repeat (12) @(posedge clk);
      #2;

      for (int i = 0; i < 16; i++)
         run("rand", 3'($urandom), 8'($urandom), 8'($urandom_range(0, 10)));

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
